// File: rtl/sw_debounce8_pkg.sv
// Purpose : shared constants and FSM encoding for the sw_debounce8 switch conditioner.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package sw_debounce8_pkg;

  // Number of consecutive differing samples that makes up 1 ms at 50 MHz.
  localparam int DEBOUNCE_1MS_50MHZ = 50000;

  // Per-bit debounce FSM encoding.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce8_debounce_bit.sv
// Purpose : synchronize and debounce one switch bit; registered rise/fall pulses.
// Latency : output updates STABLE_CYCLES+2 edges after sync1 first captures a steady new level.
// Backpr. : none; en low parks the FSM in IDLE, holds sw_stable and suppresses pulses.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   sw_raw          - raw switch level, asynchronous to clk
//   en              - debounce enable
//   sw_stable       - debounced level
//   sw_rise/sw_fall - one-cycle pulses on 0->1 / 1->0 updates of sw_stable
module debounce_bit
  import sw_debounce8_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  input  logic en,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall
);

  // Count value at which the candidate level has been seen STABLE_CYCLES times.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;

  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_stable_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_diff;

  // Two-flop synchronizer; free-running regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // Pulses default to 0 so they last exactly one cycle after an update.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;

    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_diff) begin
            if (STABLE_CYCLES == 1) begin
              // A single differing sample is enough: flip without visiting PENDING.
              w_stable_nxt = r_sync2;
              w_rise_nxt   = r_sync2;
              w_fall_nxt   = ~r_sync2;
            end else begin
              w_state_nxt = ST_PENDING;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_PENDING: begin
          if (!w_diff) begin
            // Bounced back to the current level: abandon the candidate.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST_CNT) begin
            w_stable_nxt = r_sync2;
            w_rise_nxt   = r_sync2;
            w_fall_nxt   = ~r_sync2;
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign sw_stable = r_stable;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;

endmodule

// File: rtl/sw_debounce8.sv
// Purpose : 8-bit slide-switch conditioner feeding the priority encoder; per-bit debounce + edge pulses.
// Latency : sw_stable/pulses/changed update STABLE_CYCLES+2 edges after a steady raw change is first captured.
// Backpr. : none; en low freezes sw_stable, restarts all counts and suppresses pulses.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   sw_raw[WIDTH]   - raw switch levels, asynchronous to clk
//   en              - debounce enable
//   sw_stable       - debounced vector for the encoder input
//   sw_rise/sw_fall - per-bit one-cycle update pulses
//   changed         - one-cycle strobe when any bit updated on this edge
module sw_debounce8
  import sw_debounce8_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             en,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_debounce_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw_raw    (sw_raw[g]),
      .en        (en),
      .sw_stable (sw_stable[g]),
      .sw_rise   (sw_rise[g]),
      .sw_fall   (sw_fall[g])
    );
  end

  // Built only from registered pulses, so it is glitch-free and a single pulse
  // no matter how many bits updated together.
  assign changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce8.sv
module tb_sw_debounce8;

  typedef struct {
    int         cyc;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic       en;
  logic [7:0] sw_stable;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       changed;

  int         cyc;
  int         tests;
  int         fails;
  logic [7:0] mdl_stable;
  exp_t       sb_q[$];

  sw_debounce8 #(
    .WIDTH         (8),
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .en        (en),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .changed   (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected update lands at edge 6 counted from the next rising edge.
  task automatic drive_expect(input logic [7:0] raw, input logic [7:0] st,
                              input logic [7:0] ri, input logic [7:0] fa);
    exp_t e;
    sw_raw   = raw;
    e.cyc    = cyc + 6;
    e.stable = st;
    e.rise   = ri;
    e.fall   = fa;
    sb_q.push_back(e);
    repeat (10) @(negedge clk);
  endtask

  // Monitor: changed acts as the output valid; otherwise outputs must hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (changed) begin
          chk("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("upd_cycle", cyc, e.cyc);
            chk("upd_stable", sw_stable, e.stable);
            chk("upd_rise", sw_rise, e.rise);
            chk("upd_fall", sw_fall, e.fall);
            mdl_stable = e.stable;
          end
        end else begin
          chk("hold_stable", sw_stable, mdl_stable);
          chk("idle_rise", sw_rise, 0);
          chk("idle_fall", sw_fall, 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    tests      = 0;
    fails      = 0;
    mdl_stable = 8'h00;
    rst_n      = 1'b0;
    en         = 1'b1;
    sw_raw     = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stable", sw_stable, 0);
    chk("rst_rise", sw_rise, 0);
    chk("rst_fall", sw_fall, 0);
    chk("rst_changed", changed, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("quiet_stable", sw_stable, 0);

    // Single bit rises
    drive_expect(8'h20, 8'h20, 8'h20, 8'h00);

    // Bit 3 high for only 3 cycles: must be rejected
    sw_raw = 8'h28;
    repeat (3) @(negedge clk);
    sw_raw = 8'h20;
    repeat (8) @(negedge clk);
    chk("glitch_stable", sw_stable, 8'h20);
    // Then held high
    drive_expect(8'h28, 8'h28, 8'h08, 8'h00);

    // Back to zero, then two bits together, then release
    drive_expect(8'h00, 8'h00, 8'h00, 8'h28);
    drive_expect(8'h81, 8'h81, 8'h81, 8'h00);
    drive_expect(8'h00, 8'h00, 8'h00, 8'h81);

    // Drop en while pending at cnt=2
    sw_raw = 8'h01;
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);
    chk("en_low_stable", sw_stable, 8'h00);
    en       = 1'b1;
    e.cyc    = cyc + 4;
    e.stable = 8'h01;
    e.rise   = 8'h01;
    e.fall   = 8'h00;
    sb_q.push_back(e);
    repeat (10) @(negedge clk);

    // All ones, then async reset in the middle of a pending change
    drive_expect(8'hFF, 8'hFF, 8'hFE, 8'h00);
    sw_raw = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    rst_n      = 1'b0;
    mdl_stable = 8'h00;
    sw_raw     = 8'hFF;
    #1;
    chk("arst_stable", sw_stable, 0);
    chk("arst_rise", sw_rise, 0);
    chk("arst_fall", sw_fall, 0);
    chk("arst_changed", changed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_expect(8'hFF, 8'hFF, 8'hFF, 8'h00);

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
